// File: rtl/usr_sw_conditioner.sv
// DIP-switch conditioner: two-flop synchroniser, per-bit debounce, registered
// rise/fall strobes and a wrap-around count of accepted changes.
module usr_sw_conditioner #(
  parameter int unsigned     WIDTH           = 8,
  parameter int unsigned     DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned     CNT_W           = 21,
  parameter logic [WIDTH-1:0] RESET_VALUE    = 8'h00
) (
  input  logic             sys0_clk,
  input  logic             sys0_rst,
  input  logic [WIDTH-1:0] usr_sw_i,
  input  logic             clear_count,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic [15:0]      change_count
);

  generate
    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_cfg
      $error("usr_sw_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  // A bit is accepted on the edge where its disagreeing count reaches the last value.
  always_comb begin
    accept = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      accept[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      sync1        <= RESET_VALUE;
      sync2        <= RESET_VALUE;
      sw_stable    <= RESET_VALUE;
      sw_rise      <= '0;
      sw_fall      <= '0;
      sw_changed   <= 1'b0;
      change_count <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= usr_sw_i;
      sync2 <= sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      sw_stable  <= sw_stable ^ accept;
      sw_rise    <= accept & sync2;
      sw_fall    <= accept & ~sync2;
      sw_changed <= |accept;
      // Clear wins over an increment landing on the same edge.
      if (clear_count) begin
        change_count <= '0;
      end else if (sw_changed) begin
        change_count <= change_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_usr_sw_conditioner.sv
// Directed bench for usr_sw_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_usr_sw_conditioner;

  logic        sys0_clk = 1'b0;
  logic        sys0_rst;
  logic [7:0]  usr_sw_i;
  logic        clear_count;
  logic [7:0]  sw_stable;
  logic [7:0]  sw_rise;
  logic [7:0]  sw_fall;
  logic        sw_changed;
  logic [15:0] change_count;

  int n_total = 0;
  int n_pass  = 0;

  usr_sw_conditioner #(
    .WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(3), .RESET_VALUE(8'h00)
  ) dut (
    .sys0_clk(sys0_clk), .sys0_rst(sys0_rst), .usr_sw_i(usr_sw_i),
    .clear_count(clear_count), .sw_stable(sw_stable), .sw_rise(sw_rise),
    .sw_fall(sw_fall), .sw_changed(sw_changed), .change_count(change_count)
  );

  always #5 sys0_clk = ~sys0_clk;

  typedef struct {
    logic [7:0]  sw;
    logic        clr;
    int          cycles;
    logic [7:0]  stable;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        chg;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys0_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] ri,
                         input logic [7:0] fa, input logic ch, input logic [15:0] ct);
    chk({tag, ".sw_stable"},    16'(sw_stable),  16'(st));
    chk({tag, ".sw_rise"},      16'(sw_rise),    16'(ri));
    chk({tag, ".sw_fall"},      16'(sw_fall),    16'(fa));
    chk({tag, ".sw_changed"},   16'(sw_changed), 16'(ch));
    chk({tag, ".change_count"}, change_count,    ct);
  endtask

  function automatic vec_t mk(logic [7:0] sw, logic clr, int cycles, logic [7:0] st,
                              logic [7:0] ri, logic [7:0] fa, logic ch, logic [15:0] ct);
    vec_t v;
    v.sw = sw; v.clr = clr; v.cycles = cycles; v.stable = st;
    v.rise = ri; v.fall = fa; v.chg = ch; v.cnt = ct;
    return v;
  endfunction

  initial begin
    logic [7:0] pins;

    // idle, then a clean rise of bit 0 (visible on the 6th edge after the change)
    vecs.push_back(mk(8'h00, 0, 20, 8'h00, 8'h00, 8'h00, 0, 16'd0));
    vecs.push_back(mk(8'h01, 0,  5, 8'h00, 8'h00, 8'h00, 0, 16'd0));
    vecs.push_back(mk(8'h01, 0,  1, 8'h01, 8'h01, 8'h00, 1, 16'd0));
    vecs.push_back(mk(8'h01, 0,  1, 8'h01, 8'h00, 8'h00, 0, 16'd1));
    vecs.push_back(mk(8'h01, 0, 10, 8'h01, 8'h00, 8'h00, 0, 16'd1));
    // 3-cycle glitch on bit 2 is rejected
    vecs.push_back(mk(8'h05, 0,  3, 8'h01, 8'h00, 8'h00, 0, 16'd1));
    vecs.push_back(mk(8'h01, 0, 10, 8'h01, 8'h00, 8'h00, 0, 16'd1));
    // bit 2 held high is accepted, then its fall
    vecs.push_back(mk(8'h05, 0,  5, 8'h01, 8'h00, 8'h00, 0, 16'd1));
    vecs.push_back(mk(8'h05, 0,  1, 8'h05, 8'h04, 8'h00, 1, 16'd1));
    vecs.push_back(mk(8'h05, 0,  1, 8'h05, 8'h00, 8'h00, 0, 16'd2));
    vecs.push_back(mk(8'h05, 0, 10, 8'h05, 8'h00, 8'h00, 0, 16'd2));
    vecs.push_back(mk(8'h01, 0,  5, 8'h05, 8'h00, 8'h00, 0, 16'd2));
    vecs.push_back(mk(8'h01, 0,  1, 8'h01, 8'h00, 8'h04, 1, 16'd2));
    vecs.push_back(mk(8'h01, 0,  1, 8'h01, 8'h00, 8'h00, 0, 16'd3));
    vecs.push_back(mk(8'h01, 0, 10, 8'h01, 8'h00, 8'h00, 0, 16'd3));
    // up to 0F, then 0F -> F0 in one cycle
    vecs.push_back(mk(8'h0F, 0,  5, 8'h01, 8'h00, 8'h00, 0, 16'd3));
    vecs.push_back(mk(8'h0F, 0,  1, 8'h0F, 8'h0E, 8'h00, 1, 16'd3));
    vecs.push_back(mk(8'h0F, 0,  1, 8'h0F, 8'h00, 8'h00, 0, 16'd4));
    vecs.push_back(mk(8'h0F, 0, 10, 8'h0F, 8'h00, 8'h00, 0, 16'd4));
    vecs.push_back(mk(8'hF0, 0,  5, 8'h0F, 8'h00, 8'h00, 0, 16'd4));
    vecs.push_back(mk(8'hF0, 0,  1, 8'hF0, 8'hF0, 8'h0F, 1, 16'd4));
    vecs.push_back(mk(8'hF0, 0,  1, 8'hF0, 8'h00, 8'h00, 0, 16'd5));
    vecs.push_back(mk(8'hF0, 0, 10, 8'hF0, 8'h00, 8'h00, 0, 16'd5));
    // clear, then a 1-cycle dropout on bit 7
    vecs.push_back(mk(8'hF0, 1,  1, 8'hF0, 8'h00, 8'h00, 0, 16'd0));
    vecs.push_back(mk(8'h70, 0,  1, 8'hF0, 8'h00, 8'h00, 0, 16'd0));
    vecs.push_back(mk(8'hF0, 0, 10, 8'hF0, 8'h00, 8'h00, 0, 16'd0));

    sys0_rst = 1'b1; usr_sw_i = 8'h00; clear_count = 1'b0;
    step(3);
    chk_all("reset", 8'h00, 8'h00, 8'h00, 0, 16'd0);
    sys0_rst = 1'b0;

    foreach (vecs[i]) begin
      usr_sw_i = vecs[i].sw;
      clear_count = vecs[i].clr;
      step(vecs[i].cycles);
      chk_all($sformatf("vec%0d", i), vecs[i].stable, vecs[i].rise, vecs[i].fall,
              vecs[i].chg, vecs[i].cnt);
    end
    clear_count = 1'b0;

    // 65535 changes: bits 0..3 toggle in round-robin, so one acceptance per edge
    pins = 8'hF0;
    for (int n = 0; n < 65535; n++) begin
      pins = pins ^ 8'(1 << (n % 4));
      usr_sw_i = pins;
      step(1);
    end
    step(20);
    chk("wrap.preload", change_count, 16'hFFFF);
    pins[0] = ~pins[0]; usr_sw_i = pins;
    step(6);
    chk("wrap.pulse", 16'(sw_changed), 16'd1);
    chk("wrap.before", change_count, 16'hFFFF);
    step(1);
    chk("wrap.zero", change_count, 16'h0000);
    pins[1] = ~pins[1]; usr_sw_i = pins;
    step(7);
    chk("post_wrap.inc", change_count, 16'd1);
    pins[2] = ~pins[2]; usr_sw_i = pins;
    step(6);
    chk("clr_pri.pulse", 16'(sw_changed), 16'd1);
    clear_count = 1'b1;
    step(1);
    clear_count = 1'b0;
    chk("clr_pri.count", change_count, 16'd0);
    step(3);
    chk("clr_pri.hold", change_count, 16'd0);

    // reset mid-debounce discards the partial count
    sys0_rst = 1'b1; usr_sw_i = 8'h00;
    step(1);
    sys0_rst = 1'b0;
    step(3);
    chk_all("pre_mid", 8'h00, 8'h00, 8'h00, 0, 16'd0);
    usr_sw_i = 8'h80;
    step(4);
    chk("mid.not_yet", 16'(sw_stable), 16'h00);
    sys0_rst = 1'b1;
    step(1);
    sys0_rst = 1'b0;
    chk_all("mid.reset", 8'h00, 8'h00, 8'h00, 0, 16'd0);
    step(5);
    chk_all("mid.edge5", 8'h00, 8'h00, 8'h00, 0, 16'd0);
    step(1);
    chk_all("mid.edge6", 8'h80, 8'h80, 8'h00, 1, 16'd0);
    step(1);
    chk_all("mid.edge7", 8'h80, 8'h00, 8'h00, 0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
